// File: rtl/rom_fetch_master.sv
// Instruction-fetch AXI read master with a one-line buffer: hits answer in the same cycle, misses fill a 4-beat INCR line (6 cycles to data).
// Backpressure: cpu_stall_o holds the CPU while a fill runs; arvalid_o holds until arready_i, and rready_o is asserted throughout the R phase.
module rom_fetch_master #(
    parameter logic [3:0] ARID_VAL   = 4'h0,
    parameter int         LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        flush_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_valid_o,
    output logic        cpu_err_o,
    output logic        cpu_stall_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t      state;
    logic        line_valid;
    logic [27:0] tag;
    logic [1:0]  cnt;
    logic        err_flag;
    logic        flush_pend;
    logic        err_pulse;
    logic [31:0] line_buf [4];

    logic hit;
    logic beat;
    logic beat_err;
    logic unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Hits are gated by reset so every CPU-facing output is quiet while rst is low.
    assign hit = rst && (state == IDLE) && cpu_req_i && line_valid &&
                 (tag == cpu_addr_i[31:4]) && !flush_i;

    assign cpu_valid_o = hit;
    assign cpu_stall_o = rst && cpu_req_i && !hit;
    assign cpu_rdata_o = hit ? line_buf[cpu_addr_i[3:2]] : 32'h0;
    assign cpu_err_o   = err_pulse;

    assign arid_o    = ARID_VAL;
    assign arlen_o   = 4'(LINE_WORDS - 1);
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;
    assign arvalid_o = (state == AR);
    assign rready_o  = (state == R);

    assign beat = rready_o && rvalid_i;
    // A beat arriving at cnt==3 without rlast means the burst overran the line.
    assign beat_err = (rresp_i != 2'b00) || (rid_i != ARID_VAL) ||
                      ((cnt == 2'd3) && !rlast_i);

    always_ff @(posedge clk) begin
        if (beat) begin
            line_buf[cnt] <= rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            line_valid <= 1'b0;
            tag        <= 28'h0;
            cnt        <= 2'd0;
            err_flag   <= 1'b0;
            flush_pend <= 1'b0;
            err_pulse  <= 1'b0;
            araddr_o   <= 32'h0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        line_valid <= 1'b0;
                    end
                    if (cpu_req_i && !hit) begin
                        araddr_o   <= {cpu_addr_i[31:4], 4'h0};
                        line_valid <= 1'b0;
                        cnt        <= 2'd0;
                        err_flag   <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= AR;
                    end
                end
                AR: begin
                    if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                    if (arready_i) begin
                        state <= R;
                    end
                end
                R: begin
                    if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                    if (beat) begin
                        cnt      <= cnt + 2'd1;
                        err_flag <= err_flag || beat_err;
                        if (rlast_i) begin
                            state      <= IDLE;
                            cnt        <= 2'd0;
                            err_flag   <= 1'b0;
                            flush_pend <= 1'b0;
                            // A flushed fill is silently dropped; only real failures report.
                            if (flush_pend || flush_i) begin
                                line_valid <= 1'b0;
                            end else if (!err_flag && !beat_err && (cnt == 2'd3)) begin
                                line_valid <= 1'b1;
                                tag        <= araddr_o[31:4];
                            end else begin
                                line_valid <= 1'b0;
                                err_pulse  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rom_fetch_master.md
Name: rom_fetch_master

Overview:
- AXI read master on the CPU instruction-fetch side. Sits directly upstream of the boot-ROM slave port, through the AXI interconnect.
- Converts single-word CPU fetch requests into 4-beat INCR line bursts.
- Holds the most recent line in a one-line buffer and serves sequential fetches from that buffer without bus traffic.
- Read-only: drives no AW/W/B channels.

Parameters:
- ARID_VAL, 4'h0, ID driven on arid_o and expected on rid_i.
- LINE_WORDS, 4, words per line. arlen = LINE_WORDS-1. Only the value 4 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- cpu_req_i  input  1  fetch request; held with cpu_addr_i stable while cpu_stall_o=1
- cpu_addr_i  input  32  byte address; bits [1:0] ignored
- flush_i  input  1  invalidate the line buffer
- cpu_rdata_o  output  32  fetched word
- cpu_valid_o  output  1  cpu_rdata_o valid this cycle
- cpu_err_o  output  1  one-cycle pulse: line fill failed
- cpu_stall_o  output  1  request not servable this cycle
- arid_o  output  4  =ARID_VAL
- araddr_o  output  32  line-aligned address
- arlen_o  output  4  =4'h3
- arsize_o  output  3  =3'b010
- arburst_o  output  2  =2'b01 (INCR)
- arvalid_o  output  1  AR valid
- arready_i  input  1  AR ready
- rid_i  input  4  read ID
- rdata_i  input  32  read data
- rresp_i  input  2  read response
- rlast_i  input  1  last beat
- rvalid_i  input  1  R valid
- rready_o  output  1  R ready

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, line_valid=0, tag=0, beat cnt=0, err_flag=0, araddr_o=0.
  - Outputs in reset: arvalid_o=0, rready_o=0, cpu_valid_o=0, cpu_err_o=0, cpu_stall_o=0, cpu_rdata_o=0.
  - Reset mid-burst abandons the burst; no draining.
- Hit:
  - Condition: state==IDLE, cpu_req_i=1, line_valid=1, tag==cpu_addr_i[31:4], flush_i=0.
  - Combinational response in the same cycle: cpu_valid_o=1, cpu_stall_o=0, cpu_rdata_o=buf[cpu_addr_i[3:2]].
- Miss: cpu_req_i=1 and not a hit → cpu_stall_o=1. At the edge, araddr_o<={cpu_addr_i[31:4],4'h0} and state→AR.
- cpu_stall_o=1 whenever cpu_req_i=1 and state!=IDLE.
- States:
  - IDLE: hit served; miss→AR.
  - AR: arvalid_o=1. araddr_o and the other AR fields are held stable until arready_i. arready_i=1→R.
  - R: rready_o=1. Each handshake (rvalid_i&rready_o) writes buf[cnt]<=rdata_i and increments cnt (2-bit).
    - err_flag is set if rresp_i!=2'b00 or rid_i!=ARID_VAL.
    - Handshake with rlast_i=1 → IDLE and cnt<=0.
    - On that edge: if err_flag (including the current beat) is clear and cnt==3, then line_valid<=1 and tag<=araddr_o[31:4].
    - Otherwise line_valid<=0 and cpu_err_o pulses 1 in the next cycle (IDLE). err_flag is cleared at the same time.
- Early rlast (cnt<3) or missing rlast: rlast_i is the only burst terminator. Early rlast → error path. Beats beyond 4 wrap cnt and overwrite buf; the fill is then treated as an error (err_flag set on a cnt wrap).
- Latency (arready same cycle, back-to-back beats):
  - miss seen T0; arvalid_o T1; beats T2–T5 (rlast T5); IDLE T6.
  - Re-presented request hits at T6: miss-to-data 6 cycles.
- flush_i:
  - In IDLE: line_valid<=0; a same-cycle request is treated as a miss.
  - In AR or R: the burst completes normally (AXI cannot abort) but the result is discarded, so line_valid stays 0 after rlast. A pending-flush bit carries this through.
  - No cpu_err_o is raised for a flushed fill.
- Simultaneous events:
  - A request arriving while the state is not IDLE only stalls; it is evaluated after return to IDLE.
  - arvalid_o never drops before arready_i.
  - rready_o is 0 outside R.
- Address change while stalled is a protocol violation by the CPU; behaviour is undefined.

Test Plan:
- Reset, then cpu_req_i=1, addr 0x0000_0008, slave responds 0x11,0x22,0x33,0x44 → AR araddr 0x0, arlen 3, arsize 2, arburst 1, arid 0. cpu_valid_o=1 with rdata 0x33 at T6; stall high T0–T5.
- After the first fill, requests 0x0,0x4,0xC back-to-back → data 0x11,0x22,0x44 in 3 consecutive cycles, no arvalid.
- Request 0x10 after the first line → new burst at araddr 0x10. Old line is replaced and 0x0 misses again.
- Slave holds arready_i=0 for 5 cycles → arvalid_o and araddr_o stay stable; 4 beats with rvalid gaps still fill correctly.
- Beat 2 returns rresp=2'b10 → cpu_err_o pulses 1 cycle after rlast, line_valid=0, and the next request to the same line re-issues AR.
- flush_i pulsed during beat 1 → burst drained to rlast, no cpu_err_o, and the subsequent request to the same line issues a new AR.
- Early rlast on beat 2 → cpu_err_o pulse, line_valid=0.
- rst=0 mid-R → all outputs 0 next cycle, state IDLE.
